// File: rtl/vram_sync_writer.sv
// vram_sync_writer: copies CPU-facing VRAM segments into PPU-facing VRAM
// during a sync window, all four segments in parallel.
module vram_sync_writer #(
  parameter int RD_LATENCY = 1,
  parameter int DATA_W     = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_start,
  input  logic [3:0]        sync_mask,
  output logic              sync_active,
  output logic              sync_done,
  output logic [9:0]        c_tilram_addr,
  output logic [10:0]       c_patram_addr,
  output logic [7:0]        c_palram_addr,
  output logic [4:0]        c_sprram_addr,
  output logic              c_tilram_wren,
  output logic              c_patram_wren,
  output logic              c_palram_wren,
  output logic              c_sprram_wren,
  input  logic [DATA_W-1:0] c_tilram_rddata,
  input  logic [DATA_W-1:0] c_patram_rddata,
  input  logic [DATA_W-1:0] c_palram_rddata,
  input  logic [DATA_W-1:0] c_sprram_rddata,
  output logic [9:0]        p_tilram_addr,
  output logic [10:0]       p_patram_addr,
  output logic [7:0]        p_palram_addr,
  output logic [4:0]        p_sprram_addr,
  output logic [DATA_W-1:0] p_tilram_wrdata,
  output logic [DATA_W-1:0] p_patram_wrdata,
  output logic [DATA_W-1:0] p_palram_wrdata,
  output logic [DATA_W-1:0] p_sprram_wrdata,
  output logic              p_tilram_wren,
  output logic              p_patram_wren,
  output logic              p_palram_wren,
  output logic              p_sprram_wren
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t      state;
  logic [3:0]  mask;
  logic [11:0] rc;

  logic        pv [RD_LATENCY];
  logic [10:0] pi [RD_LATENCY];

  logic        wv;
  logic [10:0] wi;
  logic        last;

  assign wv   = pv[RD_LATENCY-1];
  assign wi   = pi[RD_LATENCY-1];
  assign last = wv && (wi == 11'd2047);

  assign c_tilram_addr = rc[9:0];
  assign c_patram_addr = rc[10:0];
  assign c_palram_addr = rc[7:0];
  assign c_sprram_addr = rc[4:0];

  assign c_tilram_wren = 1'b0;
  assign c_patram_wren = 1'b0;
  assign c_palram_wren = 1'b0;
  assign c_sprram_wren = 1'b0;

  assign p_tilram_addr = wi[9:0];
  assign p_patram_addr = wi[10:0];
  assign p_palram_addr = wi[7:0];
  assign p_sprram_addr = wi[4:0];

  // indices past a segment's depth are read but dropped here
  assign p_tilram_wren = wv & mask[0] & ~wi[10];
  assign p_patram_wren = wv & mask[1];
  assign p_palram_wren = wv & mask[2] & (wi[10:8] == 3'd0);
  assign p_sprram_wren = wv & mask[3] & (wi[10:5] == 6'd0);

  // read data passes straight through, zeroed outside a write slot
  assign p_tilram_wrdata = wv ? c_tilram_rddata : '0;
  assign p_patram_wrdata = wv ? c_patram_rddata : '0;
  assign p_palram_wrdata = wv ? c_palram_rddata : '0;
  assign p_sprram_wrdata = wv ? c_sprram_rddata : '0;

  // control FSM: issue 2048 reads, then wait for the last write slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= 4'd0;
      rc          <= 12'd0;
      sync_active <= 1'b0;
      sync_done   <= 1'b0;
    end else begin
      sync_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync_start) begin
            mask        <= sync_mask;
            rc          <= 12'd0;
            state       <= READ;
            sync_active <= 1'b1;
          end
        end
        READ: begin
          if (rc == 12'd2047) begin
            rc    <= 12'd0;
            state <= DRAIN;
          end else begin
            rc <= rc + 12'd1;
          end
        end
        DRAIN: begin
          if (last) begin
            state       <= IDLE;
            sync_active <= 1'b0;
            sync_done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // delay line matching the CPU-side read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        pv[s] <= 1'b0;
        pi[s] <= 11'd0;
      end
    end else begin
      pv[0] <= (state == READ);
      pi[0] <= rc[10:0];
      for (int s = 1; s < RD_LATENCY; s++) begin
        pv[s] <= pv[s-1];
        pi[s] <= pi[s-1];
      end
    end
  end

endmodule

// File: doc/vram_sync_writer.md
Name: vram_sync_writer

Overview:
- Copies the CPU-facing VRAM (tile, pattern, palette and sprite RAMs) into the PPU-facing VRAM during a sync window, typically vblank.
- Reads the CPU-facing RAMs on port a and writes the PPU-facing RAMs on port a. All four segments are copied in parallel.
- The block owns `sync_active`, which the VRAM interconnect uses to hand PPU-facing ports away from PPU logic.
- CPU/DMA port-b writes to the CPU-facing VRAM are not blocked. Coherency is software's responsibility.

Parameters:
- RD_LATENCY, 1, CPU-facing VRAM read latency in cycles from address to rddata (legal values 1..3).
- DATA_W, 128, word width of every VRAM segment.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sync_start  in  1  single-cycle request to begin a copy
- sync_mask  in  4  segment enable {spr,pal,pat,til}; sampled with sync_start
- sync_active  out  1  high while the copy owns the PPU-facing VRAM
- sync_done  out  1  single-cycle pulse when the copy completes
- c_tilram_addr / c_patram_addr / c_palram_addr / c_sprram_addr  out  10/11/8/5  CPU-facing port-a read addresses
- c_tilram_wren / c_patram_wren / c_palram_wren / c_sprram_wren  out  1 each  CPU-facing port-a write enables; constant 0
- c_tilram_rddata / c_patram_rddata / c_palram_rddata / c_sprram_rddata  in  DATA_W each  CPU-facing port-a read data
- p_tilram_addr / p_patram_addr / p_palram_addr / p_sprram_addr  out  10/11/8/5  PPU-facing port-a write addresses
- p_tilram_wrdata / p_patram_wrdata / p_palram_wrdata / p_sprram_wrdata  out  DATA_W each  PPU-facing port-a write data
- p_tilram_wren / p_patram_wren / p_palram_wren / p_sprram_wren  out  1 each  PPU-facing port-a write enables

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Segment depths: til 1024, pat 2048, pal 256, spr 32. The copy length is always 2048 (the longest segment).
- Reset:
  - State goes to IDLE; the mask register clears.
  - Read counter, delay pipeline, all addresses, wrdata and wren go to 0.
  - sync_active and sync_done go to 0.
- States: IDLE, READ, DRAIN.
- IDLE:
  - On sync_start, latch sync_mask, clear the 12-bit read counter rc, and go to READ.
  - sync_active asserts on the cycle after sync_start is sampled.
- READ:
  - Each cycle, drive c_*ram_addr = rc[w-1:0]; rc increments.
  - When rc == 2047 is issued, go to DRAIN next cycle.
  - Reads beyond a segment's depth are issued but never written.
- Pipeline:
  - A RD_LATENCY-deep shift register carries {valid, rc}.
  - On the cycle the read data for index i arrives: p_*ram_addr = i[w-1:0], p_*ram_wrdata = c_*ram_rddata (combinational pass-through), p_*ram_wren = valid & mask[seg] & (i < depth[seg]).
  - The first write occurs RD_LATENCY cycles after the first read address.
- DRAIN:
  - Wait until the pipeline is empty, i.e. the last write (index 2047) has issued.
  - On the cycle after the last write slot: go to IDLE, deassert sync_active and pulse sync_done.
- Timing:
  - sync_active is high for exactly 2048 + RD_LATENCY cycles.
  - No write happens outside sync_active.
- Per-segment write counts: til = 1024, pat = 2048, pal = 256, spr = 32, or 0 if the segment is masked off.
- A write occurs at most once per address per copy, in ascending address order.
- sync_start while READ or DRAIN is ignored; there is no queuing.
- sync_start on the sync_done cycle: the block is already in IDLE and accepts it, so sync_active reasserts the next cycle.
- sync_mask = 4'b0000: the full timeline still runs (sync_active and sync_done as normal) with no writes.
- Reset mid-copy: abort immediately; wren is 0 from the following cycle and no sync_done is emitted. PPU-facing contents are then partially updated, which is acceptable.
- Counters wrap only through reset or completion; rc never exceeds 2047.

Test Plan:
- Full copy: RD_LATENCY=1, mask=4'b1111, CPU RAM models preloaded with data = {seg, addr}; pulse sync_start -> sync_active high 2049 cycles; PPU models hold identical contents; write counts 1024/2048/256/32; sync_done single pulse.
- Latency: RD_LATENCY=3, mask=4'b1111 -> first p_patram_wren exactly 3 cycles after c_patram_addr=0; sync_active width 2051; contents identical.
- Masking: mask=4'b0100 -> only palette written (256 writes, addresses 0..255); other PPU segments unchanged; mask=4'b0000 -> zero writes, sync_done still pulses after 2049 cycles.
- Start while busy: sync_start at cycle 100 of a copy -> ignored, single sync_done. Back-to-back: sync_start on the sync_done cycle -> second copy starts, sync_active low for exactly one cycle between copies.
- Reset: assert reset at cycle 500 of a copy -> next cycle all wren=0, sync_active=0, no sync_done. A new sync_start afterwards performs a complete correct copy.
- Invariant check, all tests: c_*ram_wren always 0; no p_*ram_wren while sync_active=0; a p_sprram_wren with address >= 32 never occurs.
